// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode/state types and op classification for alu_seq
// Honours ALU_SEQ_DIV_EN: divide/remainder opcodes count as multi-cycle only when it is defined.
package alu_pkg;

  localparam int ALU_CTR_W = 4;

  typedef enum logic [ALU_CTR_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_MUL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b0110,
    ALU_NOT  = 4'b0111,
    ALU_AND  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_SLTU = 4'b1011,
    ALU_DIV  = 4'b1100,
    ALU_DIVU = 4'b1101,
    ALU_REM  = 4'b1110,
    ALU_REMU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_e;

  function automatic logic is_multicycle(alu_op_e op);
`ifdef ALU_SEQ_DIV_EN
    return op inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
`else
    return op == ALU_MUL;
`endif
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - issue-side and writeback-side handshake bundle for alu_seq
interface alu_seq_if #(
  parameter int XLEN  = 32,
  parameter int CTR_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [CTR_W-1:0] in_ctr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic             out_err;

  modport master (
    output in_valid, in_a, in_b, in_ctr, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ctr, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/alu_seq_iter_muldiv.sv
// rtl/alu_seq_iter_muldiv.sv - iterative radix-2 multiplier and restoring divider, one bit per cycle
// Divider datapath present only when ALU_SEQ_DIV_EN is defined.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  logic            busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e         op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] x_q, x_d;
  logic [XLEN-1:0] y_q, y_d;
`ifdef ALU_SEQ_DIV_EN
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN:0]   rem_sh;
`endif

  // The last iteration is evaluated combinationally so the result is ready XLEN cycles after load.
  assign done = busy_q && (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
`ifdef ALU_SEQ_DIV_EN
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    rem_sh = '0;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op;
      acc_d  = '0;
      x_d    = a;
      y_d    = b;
`ifdef ALU_SEQ_DIV_EN
      qneg_d = 1'b0;
      rneg_d = 1'b0;
      if (op == ALU_DIV || op == ALU_REM) begin
        qneg_d = a[XLEN-1] ^ b[XLEN-1];
        rneg_d = a[XLEN-1];
        x_d    = a[XLEN-1] ? -a : a;
        y_d    = b[XLEN-1] ? -b : b;
      end
`endif
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
      end
      if (op_q == ALU_MUL) begin
        if (y_q[0]) begin
          acc_d = acc_q + x_q;
        end
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end
`ifdef ALU_SEQ_DIV_EN
      else begin
        // x holds the dividend shifting out at the top while quotient bits shift in at the bottom.
        rem_sh = {acc_q, x_q[XLEN-1]};
        if (rem_sh >= {1'b0, y_q}) begin
          rem_sh = rem_sh - {1'b0, y_q};
          x_d    = {x_q[XLEN-2:0], 1'b1};
        end else begin
          x_d    = {x_q[XLEN-2:0], 1'b0};
        end
        acc_d = rem_sh[XLEN-1:0];
      end
`endif
    end
  end

  always_comb begin
`ifdef ALU_SEQ_DIV_EN
    case (op_q)
      ALU_DIV, ALU_DIVU: result = qneg_q ? -x_d : x_d;
      ALU_REM, ALU_REMU: result = rneg_q ? -acc_d : acc_d;
      default:           result = acc_d;
    endcase
`else
    result = acc_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= ALU_ADD;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
`ifdef ALU_SEQ_DIV_EN
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU: FSM, single-cycle ops, registered result
// ALU_SEQ_DIV_EN enables DIV/DIVU/REM/REMU; otherwise those opcodes report an error.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CTR_W = ALU_CTR_W
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_err_q, out_err_d;

  alu_op_e         op;
  logic [XLEN-1:0] a, b;
  logic [SH_W-1:0] sh;
  logic [XLEN-1:0] sc_data;
  logic            sc_err;
  logic            div_special;
  logic            accept, start;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  assign op  = alu_op_e'(bus.in_ctr);
  assign a   = bus.in_a;
  assign b   = bus.in_b;
  assign sh  = b[SH_W-1:0];

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign start  = accept && is_multicycle(op) && !div_special;

  always_comb begin
    sc_data     = '0;
    sc_err      = 1'b0;
    div_special = 1'b0;
    case (op)
      ALU_ADD:  sc_data = a + b;
      ALU_SUB:  sc_data = a - b;
      ALU_MUL:  sc_data = '0;
      ALU_SLT:  sc_data = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLL:  sc_data = a << sh;
      ALU_SRL:  sc_data = a >> sh;
      ALU_SRA:  sc_data = $unsigned($signed(a) >>> sh);
      ALU_NOT:  sc_data = ~a;
      ALU_AND:  sc_data = a & b;
      ALU_OR:   sc_data = a | b;
      ALU_XOR:  sc_data = a ^ b;
      ALU_SLTU: sc_data = {{(XLEN-1){1'b0}}, a < b};
`ifdef ALU_SEQ_DIV_EN
      // Zero divisor and signed overflow resolve immediately instead of iterating.
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
        if (b == '0) begin
          div_special = 1'b1;
          sc_data     = (op == ALU_DIV || op == ALU_DIVU) ? '1 : a;
        end else if ((op == ALU_DIV || op == ALU_REM) &&
                     a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
          div_special = 1'b1;
          sc_data     = (op == ALU_DIV) ? a : '0;
        end
      end
`endif
      default:  sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (start) begin
            state_d = BUSY;
          end else begin
            state_d    = DONE;
            out_data_d = sc_data;
            out_err_d  = sc_err;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d    = DONE;
          out_data_d = md_result;
          out_err_d  = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  alu_iter_muldiv #(
    .XLEN(XLEN)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq; expectations follow ALU_SEQ_DIV_EN
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  alu_seq_if #(.XLEN(32), .CTR_W(4)) bus ();

  alu_seq #(.XLEN(32), .CTR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail_bound(string name);
    n_checks++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endfunction

  // Monitor: latency on first valid cycle, hold stability under backpressure, data on handoff.
  logic        in_ep = 1'b0;
  logic [31:0] held;
  logic        held_err;
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0) chk("in_ready_low_while_inflight", {31'b0, bus.in_ready}, 32'd0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          fail_bound("unexpected_out_valid");
        end else if (!in_ep) begin
          in_ep    = 1'b1;
          held     = bus.out_data;
          held_err = bus.out_err;
          chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
        end else begin
          chk("hold_data", bus.out_data, held);
          chk("hold_err", {31'b0, bus.out_err}, {31'b0, held_err});
        end
        if (bus.out_ready && exp_q.size() > 0) begin
          chk("out_data", bus.out_data, exp_q[0].data);
          chk("out_err", {31'b0, bus.out_err}, {31'b0, exp_q[0].err});
          void'(exp_q.pop_front());
          in_ep = 1'b0;
        end
      end else begin
        in_ep = 1'b0;
      end
    end
  end

  task automatic send(alu_op_e op, logic [31:0] a, logic [31:0] b,
                      logic [31:0] ed, logic ee, int lat);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.in_ctr   = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_bound("in_ready_wait");
    e.data = ed;
    e.err  = ee;
    e.lat  = lat;
    e.acc  = cyc;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_bound("idle_wait");
  endtask

  task automatic run(alu_op_e op, logic [31:0] a, logic [31:0] b,
                     logic [31:0] ed, logic ee, int lat);
    send(op, a, b, ed, ee, lat);
    wait_idle();
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_ctr    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_err", {31'b0, bus.out_err}, 32'd0);

    run(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1);
    run(ALU_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1);
    run(ALU_MUL,  32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 1'b0, 33);
    run(ALU_MUL,  32'd12345,    32'd100,      32'h0012D644, 1'b0, 33);
    run(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1);
    run(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
    run(ALU_SLL,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1);
    run(ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1);
    run(ALU_NOT,  32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1);
    run(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
    run(ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1);
    run(ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1);

`ifdef ALU_SEQ_DIV_EN
    run(ALU_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 33);
    run(ALU_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 33);
    run(ALU_DIVU, 32'd10,       32'd0,        32'hFFFFFFFF, 1'b0, 1);
    run(ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    run(ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);
    run(ALU_REM,  32'd5,        32'd0,        32'd5,        1'b0, 1);
    run(ALU_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 33);
    run(ALU_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33);
`else
    run(ALU_DIV,  32'd10, 32'd2, 32'd0, 1'b1, 1);
    run(ALU_DIVU, 32'd10, 32'd2, 32'd0, 1'b1, 1);
    run(ALU_REM,  32'd10, 32'd0, 32'd0, 1'b1, 1);
    run(ALU_REMU, 32'd10, 32'd3, 32'd0, 1'b1, 1);
`endif

    // Backpressure: result must stay put while the consumer stalls.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(ALU_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1);
    repeat (5) @(negedge clk);
    chk("bp_valid_held", {31'b0, bus.out_valid}, 32'd1);
    chk("bp_data_held", bus.out_data, 32'hF8000000);
    bus.out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a multiply discards it.
    send(ALU_MUL, 32'h00000005, 32'h00000009, 32'd45, 1'b0, 33);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_mid_out_data", bus.out_data, 32'd0);
    run(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    run(ALU_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
